ecc_mem_scrub: RTL
==================

// Module: ecc_mem_scrub
// PURPOSE
//   Parametrised single-port ECC memory with Hamming SEC-DED protection.
//   - Encodes on write, and decodes and corrects on a registered read.
//   - Runs a background scrubber that walks the array and writes back corrected codewords.
//   - Provides fault-injection and error-count outputs for reliability test.
//   Successor to the fixed 16x12 SEC storage array in the memory-protection subsystem.
// PARAMETERS
//   DATA_W          12    data bits per word (>=4)
//   DEPTH           16    number of words (power of two)
//   ADDR_W          4     address width, equals log2(DEPTH)
//   SCRUB_EN        1     1 = background scrubber active, 0 = scrubber removed
//   SCRUB_INTERVAL  256   idle cycles between scrub steps (>=4)
//   localparam P    smallest P with 2^P >= DATA_W+P+1 (5 for DATA_W=12)
//   localparam CW   DATA_W+P+1 stored codeword width (Hamming + overall parity)
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous active-high reset
//   wr_en       in   1       write request
//   rd_en       in   1       read request
//   addr        in   ADDR_W  user address
//   data_in     in   DATA_W  write data
//   inj_mask    in   CW      XOR mask applied to the stored codeword on write (0 = none)
//   data_out    out  DATA_W  corrected read data
//   rd_valid    out  1       data_out valid (1-cycle pulse)
//   sec_err     out  1       single-bit error corrected on this read (pulse with rd_valid)
//   ded_err     out  1       double-bit error detected on this read, data unreliable
//   sec_count   out  16      saturating count of corrected errors (user reads + scrub)
//   ded_count   out  16      saturating count of detected double-bit errors
//   scrub_busy  out  1       scrubber FSM not in IDLE
// BEHAVIOUR
//   Reset:
//     - All array words := 0. The all-zero word is a valid codeword.
//     - data_out, rd_valid, sec_err, ded_err, counts, scrub_busy := 0.
//     - Scrub FSM := IDLE, scrub pointer := 0, interval counter := 0.
//     - A reset asserted mid-scrub aborts the step with no writeback.
//   Write:
//     - mem[addr] <= encode(data_in) ^ inj_mask at the clock edge where wr_en=1.
//   Read latency 1:
//     - rd_en=1 at edge N produces data_out/rd_valid/sec_err/ded_err after edge N+1.
//     - Outputs hold their last value while rd_valid=0. Error flags are 0 whenever rd_valid=0.
//   Same-address read and write:
//     - wr_en and rd_en together on the same addr is read-before-write.
//     - The read returns the old decoded contents.
//   Decode (syndrome S over P Hamming bits, overall parity Q):
//     - S=0, Q=0: clean.
//     - Q=1: single error. Flip the bit at position S (S=0 means the overall parity bit).
//       Assert sec_err.
//     - S!=0, Q=0: double error. Assert ded_err; data_out = raw data bits, uncorrected.
//     - A user read never writes a corrected value back to the array.
//   Counters: increment by 1 per flagged event, saturate at 16'hFFFF, never wrap.
//   Scrub FSM (SCRUB_EN=1):
//     - IDLE: counts cycles with wr_en=0 and rd_en=0. At SCRUB_INTERVAL-1 -> RD.
//     - RD: reads mem[ptr] only if wr_en=rd_en=0 this cycle, otherwise stays in RD.
//       User access always wins.
//     - CHK: decodes the word. On SEC -> WB, otherwise -> IDLE.
//     - On DED: count it and leave the word untouched.
//     - WB: writes the corrected codeword when the array is free, otherwise waits.
//       The write is cancelled if a user write hit ptr after RD.
//     - Every exit to IDLE: ptr := ptr+1 with wrap DEPTH-1 -> 0, and the interval counter clears.
//     - Scrub events update the counts but never pulse rd_valid, sec_err or ded_err.
//     - When a user-read event and a scrub event land in the same cycle, the count increments by 2.
//   SCRUB_EN=0: FSM held in IDLE, scrub_busy=0.
// TESTING
//   - Reset, then read all 16 addrs -> data_out=0, rd_valid pulses 1 cycle later, no errors.
//   - Write 12'hA5C @3, read @3 -> 12'hA5C, sec_err=0, ded_err=0.
//   - Write 12'h5A3 @7 with inj_mask=1<<4, read -> 12'h5A3, sec_err=1, sec_count=1.
//     Re-read -> sec_err=1 again (no user writeback).
//   - Write @9 with inj_mask=(1<<2)|(1<<10), read -> ded_err=1, sec_err=0, ded_count=1.
//   - Single-bit inject @0, stay idle 256+3 cycles -> scrub writes back.
//     Next read @0 -> sec_err=0, sec_count=1.
//   - Same-cycle wr 12'h111 / rd @5 holding 12'h222 -> read returns 12'h222.
//     Next read -> 12'h111. Also: rst during scrub WB -> no writeback, ptr=0.

Source files
------------

// File: rtl/ecc_mem_scrub.sv
// ecc_mem_scrub: single-port SEC-DED protected memory with a background scrubber.
//   Writes store encode(data_in) ^ inj_mask. Reads decode/correct into registered outputs
//   one cycle later. An optional scrubber walks the array during idle periods and writes
//   back corrected codewords. Saturating counters track corrected and detected errors.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, rd_en, addr       user access request and address
//   data_in, inj_mask        write data and codeword fault-injection mask
//   data_out, rd_valid       registered read data and its 1-cycle valid pulse
//   sec_err, ded_err         per-read corrected / uncorrectable error flags
//   sec_count, ded_count     saturating error counts (user reads + scrub)
//   scrub_busy               scrubber is mid-step
// Codeword layout: bit 0 is overall parity, bit i (i >= 1) is Hamming position i, so a
// non-zero syndrome is directly the index of the bit to flip.
module ecc_mem_scrub #(
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned SCRUB_EN       = 1,
  parameter int unsigned SCRUB_INTERVAL = 256,
  localparam int unsigned P             = $clog2(DATA_W + $clog2(DATA_W) + 1),
  localparam int unsigned CW            = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CW-1:0]     inj_mask,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              sec_err,
  output logic              ded_err,
  output logic [15:0]       sec_count,
  output logic [15:0]       ded_count,
  output logic              scrub_busy
);

  localparam int unsigned IW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StChk, StWb} scrub_st_e;

  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] cw;
    logic          par;
    int unsigned   j;
    cw = '0;
    j  = 0;
    for (int unsigned i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    for (int unsigned k = 0; k < P; k++) begin
      par = 1'b0;
      for (int unsigned i = 1; i < CW; i++) begin
        if (((i >> k) & 1) != 0 && (i & (i - 1)) != 0) par ^= cw[i];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  // Returns {ded, sec, corrected codeword}.
  function automatic logic [CW+1:0] fix(input logic [CW-1:0] cw);
    logic [P-1:0]  s;
    logic [CW-1:0] fixed;
    logic          sec;
    logic          ded;
    s     = '0;
    fixed = cw;
    sec   = 1'b0;
    ded   = 1'b0;
    for (int unsigned i = 1; i < CW; i++) begin
      if (cw[i]) s ^= P'(i);
    end
    if (^cw) begin
      // A syndrome pointing past the word can only come from three or more flips.
      if (32'(s) < CW) begin
        fixed[s] = ~cw[s];
        sec      = 1'b1;
      end else begin
        ded = 1'b1;
      end
    end else if (s != '0) begin
      ded = 1'b1;
    end
    return {ded, sec, fixed};
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  logic [CW-1:0]     mem [DEPTH];
  scrub_st_e         state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     scrub_cw_q, scrub_cw_d;
  logic              hit_q, hit_d;
  logic              scrub_wr, scrub_sec, scrub_ded;
  logic              idle, wr_hit;
  logic [CW+1:0]     user_fix, scrub_fix;
  logic [1:0]        sec_inc, ded_inc;
  logic [16:0]       sec_sum, ded_sum;

  assign idle      = !wr_en && !rd_en;
  assign wr_hit    = wr_en && (addr == ptr_q);
  assign user_fix  = fix(mem[addr]);
  assign scrub_fix = fix(scrub_cw_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    hit_d      = hit_q;
    scrub_cw_d = scrub_cw_q;
    scrub_wr   = 1'b0;
    scrub_sec  = 1'b0;
    scrub_ded  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (idle) begin
          if (cnt_q == IW'(SCRUB_INTERVAL - 1)) begin
            state_d = StRd;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRd: begin
        // User traffic always wins the single port.
        if (idle) begin
          scrub_cw_d = mem[ptr_q];
          hit_d      = 1'b0;
          state_d    = StChk;
        end
      end
      StChk: begin
        hit_d     = wr_hit;
        scrub_sec = scrub_fix[CW];
        scrub_ded = scrub_fix[CW+1];
        if (scrub_fix[CW]) begin
          scrub_cw_d = scrub_fix[CW-1:0];
          state_d    = StWb;
        end else begin
          state_d = StIdle;
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = '0;
        end
      end
      StWb: begin
        // A user write to ptr since the read makes the corrected copy stale.
        if (hit_q || idle) begin
          scrub_wr = !hit_q;
          state_d  = StIdle;
          ptr_d    = ptr_q + 1'b1;
          cnt_d    = '0;
        end else begin
          hit_d = wr_hit;
        end
      end
      default: state_d = StIdle;
    endcase
    if (SCRUB_EN == 0) begin
      state_d   = StIdle;
      cnt_d     = '0;
      scrub_wr  = 1'b0;
      scrub_sec = 1'b0;
      scrub_ded = 1'b0;
    end
  end

  assign sec_inc = {1'b0, rd_en & user_fix[CW]} + {1'b0, scrub_sec};
  assign ded_inc = {1'b0, rd_en & user_fix[CW+1]} + {1'b0, scrub_ded};
  assign sec_sum = {1'b0, sec_count} + 17'(sec_inc);
  assign ded_sum = {1'b0, ded_count} + 17'(ded_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= '0;
      hit_q      <= 1'b0;
      scrub_cw_q <= '0;
      data_out   <= '0;
      rd_valid   <= 1'b0;
      sec_err    <= 1'b0;
      ded_err    <= 1'b0;
      sec_count  <= '0;
      ded_count  <= '0;
    end else begin
      if (wr_en) begin
        mem[addr] <= encode(data_in) ^ inj_mask;
      end else if (scrub_wr) begin
        mem[ptr_q] <= scrub_cw_q;
      end
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      hit_q      <= hit_d;
      scrub_cw_q <= scrub_cw_d;
      rd_valid   <= rd_en;
      sec_err    <= rd_en & user_fix[CW];
      ded_err    <= rd_en & user_fix[CW+1];
      if (rd_en) data_out <= extract(user_fix[CW-1:0]);
      sec_count  <= sec_sum[16] ? 16'hFFFF : sec_sum[15:0];
      ded_count  <= ded_sum[16] ? 16'hFFFF : ded_sum[15:0];
    end
  end

  assign scrub_busy = (state_q != StIdle);

endmodule
